// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state, operator and scan-code constants for calc_entry_fsm
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  // Scan codes, bit 8 is the E0-extended flag
  localparam logic [8:0] KEY_D0       = 9'h070;
  localparam logic [8:0] KEY_D1       = 9'h069;
  localparam logic [8:0] KEY_D2       = 9'h072;
  localparam logic [8:0] KEY_D3       = 9'h07A;
  localparam logic [8:0] KEY_D4       = 9'h06B;
  localparam logic [8:0] KEY_D5       = 9'h073;
  localparam logic [8:0] KEY_D6       = 9'h074;
  localparam logic [8:0] KEY_D7       = 9'h06C;
  localparam logic [8:0] KEY_D8       = 9'h075;
  localparam logic [8:0] KEY_D9       = 9'h07D;
  localparam logic [8:0] KEY_ADD      = 9'h079;
  localparam logic [8:0] KEY_SUB      = 9'h07B;
  localparam logic [8:0] KEY_MUL      = 9'h07C;
  localparam logic [8:0] KEY_ENTER    = 9'h05A;
  localparam logic [8:0] KEY_KP_ENTER = 9'h15A;
  localparam logic [8:0] KEY_BKSP     = 9'h066;
  localparam logic [8:0] KEY_ESC      = 9'h076;

endpackage

// File: rtl/key_classify.sv
// rtl/key_classify.sv - combinational decode of a 9-bit scan code into key classes
module key_classify
  import calc_pkg::*;
(
  input  logic [8:0] last_change,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_op,
  output logic [1:0] op_code,
  output logic       is_enter,
  output logic       is_bksp,
  output logic       is_esc
);

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (last_change)
      KEY_D0:  digit = 4'd0;
      KEY_D1:  digit = 4'd1;
      KEY_D2:  digit = 4'd2;
      KEY_D3:  digit = 4'd3;
      KEY_D4:  digit = 4'd4;
      KEY_D5:  digit = 4'd5;
      KEY_D6:  digit = 4'd6;
      KEY_D7:  digit = 4'd7;
      KEY_D8:  digit = 4'd8;
      KEY_D9:  digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    is_op   = 1'b1;
    op_code = OP_ADD;
    case (last_change)
      KEY_ADD: op_code = OP_ADD;
      KEY_SUB: op_code = OP_SUB;
      KEY_MUL: op_code = OP_MUL;
      default: is_op = 1'b0;
    endcase
  end

  assign is_enter = (last_change == KEY_ENTER) || (last_change == KEY_KP_ENTER);
  assign is_bksp  = (last_change == KEY_BKSP);
  assign is_esc   = (last_change == KEY_ESC);

endmodule

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - keypad entry sequencer: operand A, operator, operand B, Enter/show
// Optional SIGNED_ENTRY_EN adds neg_a/neg_b sign flags toggled by sub on an empty operand.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [8:0]            last_change,
  output logic [2:0]            state,
  output logic [1:0]            op,
  output logic [4*DIGITS-1:0]   operand_a,
  output logic [4*DIGITS-1:0]   operand_b,
  output logic [CNT_W-1:0]      digit_cnt,
`ifdef SIGNED_ENTRY_EN
  output logic                  neg_a,
  output logic                  neg_b,
`endif
  output logic                  calc_start
);

  localparam int OPW = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic             is_digit, is_op, is_enter, is_bksp, is_esc;
  logic [3:0]       digit;
  logic [1:0]       op_code;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             calc_start_q, calc_start_d;
  logic             clear_all;
`ifdef SIGNED_ENTRY_EN
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
`endif

  key_classify u_key_classify (
    .last_change (last_change),
    .is_digit    (is_digit),
    .digit       (digit),
    .is_op       (is_op),
    .op_code     (op_code),
    .is_enter    (is_enter),
    .is_bksp     (is_bksp),
    .is_esc      (is_esc)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    calc_start_d = 1'b0;
    clear_all    = 1'b0;
`ifdef SIGNED_ENTRY_EN
    neg_a_d      = neg_a_q;
    neg_b_d      = neg_b_q;
`endif

    case (state_q)
      S_A: begin
        if (key_valid) begin
          if (is_digit) begin
            a_d = (a_q << 4) | OPW'(digit);
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = S_OP;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (is_bksp && cnt_q != '0) begin
            a_d   = a_q >> 4;
            cnt_d = cnt_q - 1'b1;
          end else if (is_op && cnt_q != '0) begin
            op_d    = op_code;
            cnt_d   = '0;
            state_d = S_B;
          end
`ifdef SIGNED_ENTRY_EN
          else if (is_op && op_code == OP_SUB) begin
            neg_a_d = ~neg_a_q;
          end
`endif
        end
      end

      S_OP: begin
        if (key_valid && is_op) begin
          op_d    = op_code;
          state_d = S_B;
        end
      end

      S_B: begin
        if (key_valid) begin
          if (is_digit) begin
            b_d = (b_q << 4) | OPW'(digit);
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (is_bksp && cnt_q != '0) begin
            b_d   = b_q >> 4;
            cnt_d = cnt_q - 1'b1;
          end else if (is_enter && cnt_q != '0) begin
            state_d      = S_SHOW;
            calc_start_d = 1'b1;
          end
`ifdef SIGNED_ENTRY_EN
          else if (is_op && op_code == OP_SUB && cnt_q == '0) begin
            neg_b_d = ~neg_b_q;
          end
`endif
        end
      end

      S_WAIT: begin
        if (key_valid && is_enter) begin
          state_d      = S_SHOW;
          calc_start_d = 1'b1;
        end
      end

      S_SHOW: begin
        if (key_valid && is_enter) clear_all = 1'b1;
      end

      default: clear_all = 1'b1;
    endcase

    // Escape overrides whatever the state logic decided, and never pulses calc_start
    if (key_valid && is_esc) clear_all = 1'b1;

    if (clear_all) begin
      state_d      = S_A;
      op_d         = OP_ADD;
      a_d          = '0;
      b_d          = '0;
      cnt_d        = '0;
      calc_start_d = 1'b0;
`ifdef SIGNED_ENTRY_EN
      neg_a_d      = 1'b0;
      neg_b_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_A;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      calc_start_q <= 1'b0;
`ifdef SIGNED_ENTRY_EN
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      calc_start_q <= calc_start_d;
`ifdef SIGNED_ENTRY_EN
      neg_a_q      <= neg_a_d;
      neg_b_q      <= neg_b_d;
`endif
    end
  end

  assign state      = state_q;
  assign op         = op_q;
  assign operand_a  = a_q;
  assign operand_b  = b_q;
  assign digit_cnt  = cnt_q;
  assign calc_start = calc_start_q;
`ifdef SIGNED_ENTRY_EN
  assign neg_a      = neg_a_q;
  assign neg_b      = neg_b_q;
`endif

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - directed-vector bench for calc_entry_fsm (DIGITS=2 and DIGITS=4 instances)
module tb_calc_entry_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        kv2, kv4;
  logic [8:0]  lc2, lc4;

  logic [2:0]  state2, state4;
  logic [1:0]  op2, op4;
  logic [7:0]  a2, b2;
  logic [15:0] a4, b4;
  logic [2:0]  cnt2, cnt4;
  logic        cs2, cs4;
`ifdef SIGNED_ENTRY_EN
  logic        neg_a2, neg_b2, neg_a4, neg_b4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.DIGITS(2), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .key_valid(kv2), .last_change(lc2),
    .state(state2), .op(op2), .operand_a(a2), .operand_b(b2), .digit_cnt(cnt2),
`ifdef SIGNED_ENTRY_EN
    .neg_a(neg_a2), .neg_b(neg_b2),
`endif
    .calc_start(cs2)
  );

  calc_entry_fsm #(.DIGITS(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .key_valid(kv4), .last_change(lc4),
    .state(state4), .op(op4), .operand_a(a4), .operand_b(b4), .digit_cnt(cnt4),
`ifdef SIGNED_ENTRY_EN
    .neg_a(neg_a4), .neg_b(neg_b4),
`endif
    .calc_start(cs4)
  );

  // Strobe one key on dut2; returns at the negedge after the accepting posedge
  task automatic press(input logic [8:0] code);
    @(negedge clk);
    lc2 = code;
    kv2 = 1'b1;
    @(negedge clk);
    kv2 = 1'b0;
  endtask

  task automatic press4(input logic [8:0] code);
    @(negedge clk);
    lc4 = code;
    kv4 = 1'b1;
    @(negedge clk);
    kv4 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state2 !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state2); end
    vectors++; if (op2 !== 2'b00) begin miscompares++; $display("FAIL reset_op got %0d exp 0", op2); end
    vectors++; if ({a2, b2} !== 16'h0) begin miscompares++; $display("FAIL reset_operands got %h exp 0000", {a2, b2}); end
    vectors++; if (cnt2 !== 3'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", cnt2); end
    vectors++; if (cs2 !== 1'b0) begin miscompares++; $display("FAIL reset_calc_start got %b exp 0", cs2); end
    vectors++; if ({state4, a4, cnt4} !== 22'h0) begin miscompares++; $display("FAIL reset_dut4 got %h exp 0", {state4, a4, cnt4}); end
  endtask

  task automatic test_full_entry();
    press(9'h072);
    vectors++; if (cnt2 !== 3'd1 || state2 !== 3'd0) begin miscompares++; $display("FAIL full_first_digit got cnt %0d st %0d exp cnt 1 st 0", cnt2, state2); end
    press(9'h06B);
    vectors++; if (a2 !== 8'h24 || state2 !== 3'd1 || cnt2 !== 3'd0) begin miscompares++; $display("FAIL full_a_advance got a %h st %0d cnt %0d exp a 24 st 1 cnt 0", a2, state2, cnt2); end
    press(9'h070);
    vectors++; if (a2 !== 8'h24 || state2 !== 3'd1) begin miscompares++; $display("FAIL digit_in_s_op got a %h st %0d exp a 24 st 1", a2, state2); end
    press(9'h079);
    vectors++; if (op2 !== 2'b00 || state2 !== 3'd2) begin miscompares++; $display("FAIL full_op got op %0d st %0d exp op 0 st 2", op2, state2); end
    press(9'h075);
    press(9'h070);
    vectors++; if (b2 !== 8'h80 || state2 !== 3'd3 || cnt2 !== 3'd0) begin miscompares++; $display("FAIL full_b_wait got b %h st %0d cnt %0d exp b 80 st 3 cnt 0", b2, state2, cnt2); end
    press(9'h066);
    vectors++; if (b2 !== 8'h80 || state2 !== 3'd3) begin miscompares++; $display("FAIL wait_ignores_bksp got b %h st %0d exp b 80 st 3", b2, state2); end
    vectors++; if (cs2 !== 1'b0) begin miscompares++; $display("FAIL calc_start_early got %b exp 0", cs2); end
    press(9'h05A);
    vectors++; if (state2 !== 3'd4 || cs2 !== 1'b1) begin miscompares++; $display("FAIL full_show got st %0d cs %b exp st 4 cs 1", state2, cs2); end
    @(negedge clk);
    vectors++; if (cs2 !== 1'b0 || a2 !== 8'h24 || b2 !== 8'h80 || op2 !== 2'b00) begin miscompares++; $display("FAIL show_stable got cs %b a %h b %h op %0d exp cs 0 a 24 b 80 op 0", cs2, a2, b2, op2); end
    press(9'h072);
    vectors++; if (state2 !== 3'd4 || a2 !== 8'h24) begin miscompares++; $display("FAIL show_ignores_digit got st %0d a %h exp st 4 a 24", state2, a2); end
    press(9'h05A);
    vectors++; if ({state2, op2, a2, b2, cnt2, cs2} !== 28'h0) begin miscompares++; $display("FAIL show_enter_clear got %h exp 0", {state2, op2, a2, b2, cnt2, cs2}); end
  endtask

  task automatic test_held_code();
    @(negedge clk);
    lc2 = 9'h070;
    kv2 = 1'b1;
    @(negedge clk);
    kv2 = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (cnt2 !== 3'd1 || state2 !== 3'd0) begin miscompares++; $display("FAIL held_code got cnt %0d st %0d exp cnt 1 st 0", cnt2, state2); end
    press(9'h170);
    vectors++; if (cnt2 !== 3'd1) begin miscompares++; $display("FAIL extended_ignored got cnt %0d exp 1", cnt2); end
    press(9'h076);
  endtask

  task automatic test_short_entry();
    press(9'h069);
    press(9'h07C);
    vectors++; if (a2 !== 8'h01 || op2 !== 2'b10 || state2 !== 3'd2 || cnt2 !== 3'd0) begin miscompares++; $display("FAIL short_a got a %h op %0d st %0d cnt %0d exp a 01 op 2 st 2 cnt 0", a2, op2, state2, cnt2); end
    press(9'h05A);
    vectors++; if (state2 !== 3'd2 || cs2 !== 1'b0) begin miscompares++; $display("FAIL empty_b_enter got st %0d cs %b exp st 2 cs 0", state2, cs2); end
    press(9'h073);
    vectors++; if (b2 !== 8'h05 || cnt2 !== 3'd1) begin miscompares++; $display("FAIL short_b_digit got b %h cnt %0d exp b 05 cnt 1", b2, cnt2); end
    press(9'h066);
    vectors++; if (b2 !== 8'h00 || cnt2 !== 3'd0 || state2 !== 3'd2) begin miscompares++; $display("FAIL bksp got b %h cnt %0d st %0d exp b 00 cnt 0 st 2", b2, cnt2, state2); end
    press(9'h066);
    vectors++; if (cnt2 !== 3'd0 || state2 !== 3'd2) begin miscompares++; $display("FAIL bksp_empty got cnt %0d st %0d exp cnt 0 st 2", cnt2, state2); end
    press(9'h07D);
    press(9'h15A);
    vectors++; if (state2 !== 3'd4 || cs2 !== 1'b1 || b2 !== 8'h09) begin miscompares++; $display("FAIL short_b_enter got st %0d cs %b b %h exp st 4 cs 1 b 09", state2, cs2, b2); end
    press(9'h076);
  endtask

  task automatic test_escape();
    press(9'h075);
    press(9'h079);
    press(9'h072);
    vectors++; if (state2 !== 3'd2 || cnt2 !== 3'd1) begin miscompares++; $display("FAIL pre_escape got st %0d cnt %0d exp st 2 cnt 1", state2, cnt2); end
    press(9'h076);
    vectors++; if ({state2, op2, a2, b2, cnt2, cs2} !== 28'h0) begin miscompares++; $display("FAIL escape got %h exp 0", {state2, op2, a2, b2, cnt2, cs2}); end
    @(negedge clk);
    vectors++; if (cs2 !== 1'b0) begin miscompares++; $display("FAIL escape_no_pulse got %b exp 0", cs2); end
  endtask

  task automatic test_reset_with_key();
    press(9'h06B);
    @(negedge clk);
    reset = 1'b1;
    lc2 = 9'h072;
    kv2 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    kv2 = 1'b0;
    vectors++; if ({state2, op2, a2, b2, cnt2, cs2} !== 28'h0) begin miscompares++; $display("FAIL reset_beats_key got %h exp 0", {state2, op2, a2, b2, cnt2, cs2}); end
  endtask

  task automatic test_digits4();
    press4(9'h07D);
    press4(9'h075);
    press4(9'h06C);
    vectors++; if (state4 !== 3'd0 || cnt4 !== 3'd3 || a4 !== 16'h0987) begin miscompares++; $display("FAIL d4_three got st %0d cnt %0d a %h exp st 0 cnt 3 a 0987", state4, cnt4, a4); end
    press4(9'h074);
    vectors++; if (state4 !== 3'd1 || cnt4 !== 3'd0 || a4 !== 16'h9876) begin miscompares++; $display("FAIL d4_advance got st %0d cnt %0d a %h exp st 1 cnt 0 a 9876", state4, cnt4, a4); end
    press4(9'h07C);
    press4(9'h069);
    press4(9'h072);
    press4(9'h07A);
    press4(9'h06B);
    vectors++; if (state4 !== 3'd3 || b4 !== 16'h1234 || op4 !== 2'b10) begin miscompares++; $display("FAIL d4_wait got st %0d b %h op %0d exp st 3 b 1234 op 2", state4, b4, op4); end
    press4(9'h15A);
    vectors++; if (state4 !== 3'd4 || cs4 !== 1'b1) begin miscompares++; $display("FAIL d4_kp_enter got st %0d cs %b exp st 4 cs 1", state4, cs4); end
    @(negedge clk);
    vectors++; if (cs4 !== 1'b0) begin miscompares++; $display("FAIL d4_pulse_width got %b exp 0", cs4); end
  endtask

  task automatic test_signed();
    press(9'h07B);
    press(9'h072);
    press(9'h079);
    vectors++; if (a2 !== 8'h02 || op2 !== 2'b00 || state2 !== 3'd2) begin miscompares++; $display("FAIL sign_seq got a %h op %0d st %0d exp a 02 op 0 st 2", a2, op2, state2); end
`ifdef SIGNED_ENTRY_EN
    vectors++; if (neg_a2 !== 1'b1 || neg_b2 !== 1'b0) begin miscompares++; $display("FAIL neg_a got %b%b exp 10", neg_a2, neg_b2); end
    press(9'h07B);
    vectors++; if (neg_b2 !== 1'b1 || op2 !== 2'b00) begin miscompares++; $display("FAIL neg_b got %b op %0d exp 1 op 0", neg_b2, op2); end
    press(9'h076);
    vectors++; if (neg_a2 !== 1'b0 || neg_b2 !== 1'b0) begin miscompares++; $display("FAIL sign_clear got %b%b exp 00", neg_a2, neg_b2); end
`else
    press(9'h076);
`endif
  endtask

  initial begin
    reset = 1'b0;
    kv2 = 1'b0;
    kv4 = 1'b0;
    lc2 = 9'h000;
    lc4 = 9'h000;
    test_reset();
    test_full_entry();
    test_held_code();
    test_short_entry();
    test_escape();
    test_reset_with_key();
    test_digits4();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
